// File: rtl/decode_pkg.sv
// Shared types for the decode queue: format tags, RV opcodes and the decoded bundle.
// Widths are held at 64 bits here and truncated to XLEN by the queue.
package decode_pkg;

   localparam int MAXW = 64;

   typedef enum logic [2:0] {
      FMT_R   = 3'd0,
      FMT_I   = 3'd1,
      FMT_S   = 3'd2,
      FMT_B   = 3'd3,
      FMT_U   = 3'd4,
      FMT_J   = 3'd5,
      FMT_ILL = 3'd6
   } fmt_e;

   localparam logic [6:0] OP_LUI    = 7'h37;
   localparam logic [6:0] OP_AUIPC  = 7'h17;
   localparam logic [6:0] OP_JAL    = 7'h6f;
   localparam logic [6:0] OP_JALR   = 7'h67;
   localparam logic [6:0] OP_LOAD   = 7'h03;
   localparam logic [6:0] OP_OPIMM  = 7'h13;
   localparam logic [6:0] OP_FENCE  = 7'h0f;
   localparam logic [6:0] OP_SYSTEM = 7'h73;
   localparam logic [6:0] OP_BRANCH = 7'h63;
   localparam logic [6:0] OP_STORE  = 7'h23;
   localparam logic [6:0] OP_OP     = 7'h33;

   typedef struct packed {
      logic [MAXW-1:0] pc;
      logic [6:0]      opcode;
      fmt_e            fmt;
      logic [4:0]      rd;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [2:0]      funct3;
      logic [6:0]      funct7;
      logic [MAXW-1:0] imm;
      logic            illegal;
   } decoded_t;

endpackage

// File: rtl/inst_decode_comb.sv
// Combinational RV32/RV64 instruction decoder producing a zero-filled decoded_t (pc left zero).
// DECODE_RV_M_EN accepts funct7=0x01 R-format (M extension) as legal.
module inst_decode_comb
   import decode_pkg::*;
(
   input  logic [31:0] inst,
   output decoded_t    dec
);

`ifdef DECODE_RV_M_EN
   localparam bit M_EXT = 1'b1;
`else
   localparam bit M_EXT = 1'b0;
`endif

   fmt_e fmt;

   always_comb begin
      fmt = FMT_ILL;
      if (inst[1:0] == 2'b11) begin
         unique case (inst[6:0])
            OP_LUI, OP_AUIPC: fmt = FMT_U;
            OP_JAL:           fmt = FMT_J;
            OP_JALR, OP_LOAD, OP_OPIMM, OP_FENCE, OP_SYSTEM: fmt = FMT_I;
            OP_BRANCH:        fmt = FMT_B;
            OP_STORE:         fmt = FMT_S;
            OP_OP: begin
               if (inst[31:25] == 7'h00 || inst[31:25] == 7'h20 ||
                   (M_EXT && inst[31:25] == 7'h01))
                  fmt = FMT_R;
            end
            default:          fmt = FMT_ILL;
         endcase
      end
   end

   // Illegal encodings keep only their opcode; every other field stays zero.
   always_comb begin
      dec         = '0;
      dec.opcode  = inst[6:0];
      dec.fmt     = fmt;
      dec.illegal = (fmt == FMT_ILL);
      case (fmt)
         FMT_R: begin
            dec.rd     = inst[11:7];
            dec.rs1    = inst[19:15];
            dec.rs2    = inst[24:20];
            dec.funct3 = inst[14:12];
            dec.funct7 = inst[31:25];
         end
         FMT_I: begin
            dec.rd     = inst[11:7];
            dec.rs1    = inst[19:15];
            dec.funct3 = inst[14:12];
            dec.imm    = {{52{inst[31]}}, inst[31:20]};
         end
         FMT_S: begin
            dec.rs1    = inst[19:15];
            dec.rs2    = inst[24:20];
            dec.funct3 = inst[14:12];
            dec.imm    = {{52{inst[31]}}, inst[31:25], inst[11:7]};
         end
         FMT_B: begin
            dec.rs1    = inst[19:15];
            dec.rs2    = inst[24:20];
            dec.funct3 = inst[14:12];
            dec.imm    = {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
         end
         FMT_U: begin
            dec.rd     = inst[11:7];
            dec.imm    = {{32{inst[31]}}, inst[31:12], 12'b0};
         end
         FMT_J: begin
            dec.rd     = inst[11:7];
            dec.imm    = {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/decode_queue.sv
// Decode stage: decodes fetched instructions and buffers them in a DEPTH-entry FIFO with flush.
// DECODE_RV_M_EN (in inst_decode_comb) makes M-extension R-format encodings legal.
module decode_queue
   import decode_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [31:0]                in_inst,
   input  logic [XLEN-1:0]            in_pc,
   input  logic                       flush,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [XLEN-1:0]            out_pc,
   output logic [6:0]                 out_opcode,
   output logic [2:0]                 out_funct3,
   output logic [6:0]                 out_funct7,
   output logic [4:0]                 out_rd,
   output logic [4:0]                 out_rs1,
   output logic [4:0]                 out_rs2,
   output logic [2:0]                 out_fmt,
   output logic [XLEN-1:0]            out_imm,
   output logic                       out_illegal,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   decoded_t        mem [DEPTH];
   decoded_t        dec_in;
   decoded_t        entry;
   decoded_t        head_e;
   logic [PW-1:0]   head;
   logic [PW-1:0]   tail;
   logic            push;
   logic            pop;

   inst_decode_comb u_dec (
      .inst (in_inst),
      .dec  (dec_in)
   );

   always_comb begin
      entry    = dec_in;
      entry.pc = MAXW'(in_pc);
   end

   assign in_ready  = rst_n && (count != CW'(DEPTH));
   assign out_valid = (count != '0);
   assign push      = in_valid && in_ready && !flush;
   assign pop       = out_valid && out_ready && !flush;

   // Pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            mem[tail] <= entry;
            tail      <= tail + PW'(1);
         end
         if (pop) head <= head + PW'(1);
         if (push && !pop)      count <= count + CW'(1);
         else if (pop && !push) count <= count - CW'(1);
      end
   end

   assign head_e      = mem[head];
   assign out_pc      = head_e.pc[XLEN-1:0];
   assign out_opcode  = head_e.opcode;
   assign out_funct3  = head_e.funct3;
   assign out_funct7  = head_e.funct7;
   assign out_rd      = head_e.rd;
   assign out_rs1     = head_e.rs1;
   assign out_rs2     = head_e.rs2;
   assign out_fmt     = head_e.fmt;
   assign out_imm     = head_e.imm[XLEN-1:0];
   assign out_illegal = head_e.illegal;

endmodule

// File: tb/tb_decode_queue.sv
// Scoreboard bench for decode_queue: directed plan vectors then randomized traffic vs a queue model.
// Honours DECODE_RV_M_EN for the expected legality of M-extension encodings.
module tb_decode_queue;
   import decode_pkg::*;

   localparam int XLEN  = 32;
   localparam int DEPTH = 2;
   localparam int CW    = $clog2(DEPTH+1);

   logic              clk = 1'b0;
   logic              rst_n;
   logic              in_valid;
   logic              in_ready;
   logic [31:0]       in_inst;
   logic [XLEN-1:0]   in_pc;
   logic              flush;
   logic              out_valid;
   logic              out_ready;
   logic [XLEN-1:0]   out_pc;
   logic [6:0]        out_opcode;
   logic [2:0]        out_funct3;
   logic [6:0]        out_funct7;
   logic [4:0]        out_rd;
   logic [4:0]        out_rs1;
   logic [4:0]        out_rs2;
   logic [2:0]        out_fmt;
   logic [XLEN-1:0]   out_imm;
   logic              out_illegal;
   logic [CW-1:0]     count;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [63:0] pc;
      logic [6:0]  opcode;
      fmt_e        fmt;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [63:0] imm;
      logic        ill;
   } exp_t;

   exp_t exp_q[$];

   decode_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_inst(in_inst), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .out_pc(out_pc), .out_opcode(out_opcode),
      .out_funct3(out_funct3), .out_funct7(out_funct7), .out_rd(out_rd),
      .out_rs1(out_rs1), .out_rs2(out_rs2), .out_fmt(out_fmt), .out_imm(out_imm),
      .out_illegal(out_illegal), .count(count)
   );

   always #5 clk = ~clk;

   // Reference decode built from the ISA rules with arithmetic shifts on a sign-extended word.
   function automatic exp_t ref_decode(logic [31:0] w, logic [63:0] pc);
      exp_t   e;
      longint s;
      bit     m_ok;
`ifdef DECODE_RV_M_EN
      m_ok = 1'b1;
`else
      m_ok = 1'b0;
`endif
      e = '{pc: pc, opcode: w[6:0], fmt: FMT_ILL, rd: 0, rs1: 0, rs2: 0,
            f3: 0, f7: 0, imm: 0, ill: 0};
      s = longint'($signed(w));
      if (w[1:0] == 2'b11) begin
         case (w[6:0])
            7'h37, 7'h17: e.fmt = FMT_U;
            7'h6f:        e.fmt = FMT_J;
            7'h67, 7'h03, 7'h13, 7'h0f, 7'h73: e.fmt = FMT_I;
            7'h63:        e.fmt = FMT_B;
            7'h23:        e.fmt = FMT_S;
            7'h33:        if (w[31:25] == 7'h00 || w[31:25] == 7'h20 || (m_ok && w[31:25] == 7'h01))
                             e.fmt = FMT_R;
            default:      e.fmt = FMT_ILL;
         endcase
      end
      e.ill = (e.fmt == FMT_ILL);
      if (e.fmt inside {FMT_R, FMT_I, FMT_U, FMT_J}) e.rd  = w[11:7];
      if (e.fmt inside {FMT_R, FMT_I, FMT_S, FMT_B}) begin
         e.rs1 = w[19:15];
         e.f3  = w[14:12];
      end
      if (e.fmt inside {FMT_R, FMT_S, FMT_B}) e.rs2 = w[24:20];
      if (e.fmt == FMT_R) e.f7 = w[31:25];
      case (e.fmt)
         FMT_I: e.imm = s >>> 20;
         FMT_S: e.imm = ((s >>> 25) << 5) | longint'(w[11:7]);
         FMT_B: e.imm = ((s >>> 31) << 12) | (longint'(w[7]) << 11) |
                        (longint'(w[30:25]) << 5) | (longint'(w[11:8]) << 1);
         FMT_U: e.imm = (s >>> 12) << 12;
         FMT_J: e.imm = ((s >>> 31) << 20) | (longint'(w[19:12]) << 12) |
                        (longint'(w[20]) << 11) | (longint'(w[30:21]) << 1);
         default: e.imm = 64'd0;
      endcase
      return e;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic rst, input logic v, input logic [31:0] inst,
                                input logic [XLEN-1:0] pc, input logic rdy, input logic fl);
      @(negedge clk);
      #1;
      rst_n     = rst;
      in_valid  = v;
      in_inst   = inst;
      in_pc     = pc;
      out_ready = rdy;
      flush     = fl;
   endtask

   // Model: sample the handshake at each edge using only the model's own occupancy.
   always @(posedge clk) begin
      bit do_push, do_pop;
      if (!rst_n || flush) begin
         exp_q.delete();
      end else begin
         do_pop  = (exp_q.size() > 0) && out_ready;
         do_push = in_valid && (exp_q.size() < DEPTH);
         if (do_pop) void'(exp_q.pop_front());
         if (do_push) exp_q.push_back(ref_decode(in_inst, 64'(in_pc)));
      end
   end

   // Monitor: compare the presented head and status against the model away from the edge.
   always @(negedge clk) begin
      exp_t e;
      checkOutput("count", 64'(count), 64'(exp_q.size()));
      checkOutput("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
      checkOutput("in_ready", 64'(in_ready), 64'(rst_n && exp_q.size() != DEPTH));
      if (out_valid && exp_q.size() != 0) begin
         e = exp_q[0];
         checkOutput("head_pc", 64'(out_pc), 64'(e.pc[XLEN-1:0]));
         checkOutput("head_opcode", 64'(out_opcode), 64'(e.opcode));
         checkOutput("head_fmt", 64'(out_fmt), 64'(e.fmt));
         checkOutput("head_rd", 64'(out_rd), 64'(e.rd));
         checkOutput("head_rs1", 64'(out_rs1), 64'(e.rs1));
         checkOutput("head_rs2", 64'(out_rs2), 64'(e.rs2));
         checkOutput("head_funct3", 64'(out_funct3), 64'(e.f3));
         checkOutput("head_funct7", 64'(out_funct7), 64'(e.f7));
         checkOutput("head_imm", 64'(out_imm), 64'(e.imm[XLEN-1:0]));
         checkOutput("head_illegal", 64'(out_illegal), 64'(e.ill));
      end
   end

   logic [6:0] ops [11] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h03, 7'h13,
                           7'h0f, 7'h73, 7'h63, 7'h23, 7'h33};

   initial begin
      logic [31:0] w;
      int sel;
      rst_n = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b0; flush = 1'b0;
      repeat (3) applyStimulus(1'b0, 1'b0, 32'd0, '0, 1'b0, 1'b1);
      @(posedge clk); #1;
      checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
      checkOutput("reset_in_ready", 64'(in_ready), 64'd0);
      checkOutput("reset_imm", 64'(out_imm), 64'd0);
      checkOutput("reset_pc", 64'(out_pc), 64'd0);
      applyStimulus(1'b1, 1'b0, 32'd0, '0, 1'b1, 1'b0);
      @(posedge clk); #1;
      checkOutput("release_in_ready", 64'(in_ready), 64'd1);

      applyStimulus(1'b1, 1'b1, 32'hFFF10093, 32'h100, 1'b1, 1'b0);
      @(posedge clk); #1;
      checkOutput("addi_valid", 64'(out_valid), 64'd1);
      checkOutput("addi_fmt", 64'(out_fmt), 64'(FMT_I));
      checkOutput("addi_rd", 64'(out_rd), 64'd1);
      checkOutput("addi_rs1", 64'(out_rs1), 64'd2);
      checkOutput("addi_rs2", 64'(out_rs2), 64'd0);
      checkOutput("addi_imm", 64'(out_imm), 64'hFFFFFFFF);
      checkOutput("addi_pc", 64'(out_pc), 64'h100);

      applyStimulus(1'b1, 1'b1, 32'h123452B7, 32'h104, 1'b1, 1'b0);
      @(posedge clk); #1;
      checkOutput("lui_fmt", 64'(out_fmt), 64'(FMT_U));
      checkOutput("lui_rd", 64'(out_rd), 64'd5);
      checkOutput("lui_imm", 64'(out_imm), 64'h12345000);
      checkOutput("lui_rs1", 64'(out_rs1), 64'd0);

      applyStimulus(1'b1, 1'b1, 32'hFE208EE3, 32'h108, 1'b1, 1'b0);
      @(posedge clk); #1;
      checkOutput("beq_fmt", 64'(out_fmt), 64'(FMT_B));
      checkOutput("beq_rs2", 64'(out_rs2), 64'd2);
      checkOutput("beq_rd", 64'(out_rd), 64'd0);
      checkOutput("beq_imm", 64'(out_imm), 64'hFFFFFFFC);

      applyStimulus(1'b1, 1'b0, 32'd0, '0, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b1, 32'h002081B3, 32'h200, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 32'h002081B3, 32'h204, 1'b0, 1'b0);
      @(posedge clk); #1;
      checkOutput("full_count", 64'(count), 64'd2);
      checkOutput("full_in_ready", 64'(in_ready), 64'd0);
      applyStimulus(1'b1, 1'b1, 32'h002081B3, 32'h208, 1'b0, 1'b0);
      @(posedge clk); #1;
      checkOutput("held_count", 64'(count), 64'd2);
      checkOutput("held_head_pc", 64'(out_pc), 64'h200);
      applyStimulus(1'b1, 1'b1, 32'h002081B3, 32'h208, 1'b1, 1'b0);
      @(posedge clk); #1;
      checkOutput("drain1_pc", 64'(out_pc), 64'h204);
      checkOutput("drain1_count", 64'(count), 64'd1);
      @(posedge clk); #1;
      checkOutput("drain2_pc", 64'(out_pc), 64'h208);
      checkOutput("drain2_count", 64'(count), 64'd1);
      applyStimulus(1'b1, 1'b0, 32'd0, '0, 1'b1, 1'b0);

      applyStimulus(1'b1, 1'b1, 32'h00000013, 32'h300, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 32'h00000013, 32'h304, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 32'h00000013, 32'h308, 1'b1, 1'b1);
      @(posedge clk); #1;
      checkOutput("flush_count", 64'(count), 64'd0);
      checkOutput("flush_out_valid", 64'(out_valid), 64'd0);
      applyStimulus(1'b1, 1'b0, 32'd0, '0, 1'b0, 1'b0);
      @(posedge clk); #1;
      checkOutput("flush_dropped", 64'(out_valid), 64'd0);

      applyStimulus(1'b1, 1'b1, 32'h00000000, 32'h400, 1'b1, 1'b0);
      @(posedge clk); #1;
      checkOutput("zero_illegal", 64'(out_illegal), 64'd1);
      checkOutput("zero_fmt", 64'(out_fmt), 64'(FMT_ILL));
      checkOutput("zero_imm", 64'(out_imm), 64'd0);

      applyStimulus(1'b1, 1'b1, 32'h022081B3, 32'h404, 1'b1, 1'b0);
      @(posedge clk); #1;
`ifdef DECODE_RV_M_EN
      checkOutput("mul_fmt", 64'(out_fmt), 64'(FMT_R));
      checkOutput("mul_rd", 64'(out_rd), 64'd3);
      checkOutput("mul_funct7", 64'(out_funct7), 64'h01);
`else
      checkOutput("mul_fmt", 64'(out_fmt), 64'(FMT_ILL));
      checkOutput("mul_illegal", 64'(out_illegal), 64'd1);
      checkOutput("mul_rd", 64'(out_rd), 64'd0);
`endif
      applyStimulus(1'b1, 1'b0, 32'd0, '0, 1'b1, 1'b0);

      for (int n = 0; n < 3000; n++) begin
         w   = $urandom;
         sel = $urandom_range(0, 13);
         if (sel < 11) begin
            w[6:0] = ops[sel];
            if (ops[sel] == 7'h33) begin
               case ($urandom_range(0, 3))
                  0: w[31:25] = 7'h00;
                  1: w[31:25] = 7'h20;
                  2: w[31:25] = 7'h01;
                  default: ;
               endcase
            end
         end
         applyStimulus($urandom_range(0, 199) != 0, $urandom_range(0, 3) != 0, w,
                       XLEN'($urandom), $urandom_range(0, 2) != 0, $urandom_range(0, 29) == 0);
      end

      applyStimulus(1'b1, 1'b0, 32'd0, '0, 1'b1, 1'b0);
      repeat (4) @(negedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/decode_queue.md
# decode_queue

Parametrised decode stage between fetch and execute/dmem. Accepts raw RV32/RV64 instruction words with their PC over a valid/ready handshake, and decodes each into a format tag, register fields, funct fields and a fully assembled, sign-extended immediate. Decoded bundles go into a DEPTH-entry FIFO. A synchronous flush drops all queued work after a branch redirect. Unused fields are always zero, and unknown encodings are tagged illegal instead of passing through stale values.

## Interface
- XLEN, 32: datapath width; 32 or 64. Sets the width of pc and immediate.
- DEPTH, 2: queue entries; power of two, ≥2.
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  fetch offers an instruction
- in_ready  out  1  queue can accept; equals rst_n && count != DEPTH
- in_inst  in  32  raw instruction word
- in_pc  in  XLEN  PC of in_inst
- flush  in  1  discard all queued entries
- out_valid  out  1  head entry valid
- out_ready  in  1  consumer takes head
- out_pc  out  XLEN  PC of head
- out_opcode / out_funct3 / out_funct7  out  7/3/7  instruction fields
- out_rd / out_rs1 / out_rs2  out  5/5/5  register indices
- out_fmt  out  3  format tag (R, I, S, B, U, J, ILL)
- out_imm  out  XLEN  sign-extended immediate
- out_illegal  out  1  head entry is an illegal encoding
- count  out  $clog2(DEPTH+1)  occupied entries

## Operation
- Push occurs when in_valid && in_ready && !flush. Pop occurs when out_valid && out_ready && !flush.
- Decode is combinational on in_inst. The result is written into the tail entry on push. The out_* signals are driven from the head entry.
- Format by opcode:
  - U: 0x37, 0x17
  - J: 0x6f
  - I: 0x67, 0x03, 0x13, 0x0f, 0x73
  - B: 0x63
  - S: 0x23
  - R: 0x33
- Immediates:
  - U: {inst[31:12], 12'b0}
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}
  - I: inst[31:20]
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}
  - S: {inst[31:25], inst[11:7]}
  - R: 0
  - Every immediate is sign-extended from its MSB to XLEN.
- Field population (fields not listed are zero):
  - rd: R, I, U, J
  - rs1 and funct3: R, I, S, B
  - rs2: R, S, B
  - funct7: R only
- Illegal encodings:
  - inst[1:0] != 2'b11, or opcode not in the list above.
  - R with funct7 not in {0x00, 0x20}.
  - An illegal instruction is still enqueued with fmt=ILL, out_illegal=1, its opcode and pc, and all other fields zero.
- Simultaneous push and pop leaves count unchanged and is legal at any occupancy below DEPTH. When full, in_ready=0 even if out_ready=1; there is no combinational ready path.
- Pointers wrap modulo DEPTH.
- Flush: count, head and tail are cleared at the edge. A push or pop offered in the same cycle is discarded.

## Timing
- Reset values: out_valid=0, count=0, pointers=0, all storage and out_* = 0. in_ready=0 while rst_n=0 and 1 in the first cycle after release.
- Latency: an instruction pushed at edge N appears at the out_* signals after edge N (out_valid=1 in cycle N+1 if the queue was empty).
- out_* stay stable while out_valid && !out_ready.
- in_ready and out_valid depend only on registered state; neither is combinational from any input.
- Flush during reset: reset dominates. Reset mid-stream discards all entries.

## Configuration
- DECODE_RV_M_EN defined: an R-format instruction with funct7=0x01 is legal (M extension) and is decoded as R.
- Undefined: the same encoding is illegal (fmt=ILL, out_illegal=1).

## Structure
- decode_pkg holds:
  - fmt_e enum (3 bits).
  - Opcode localparams (OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_OPIMM, OP_FENCE, OP_SYSTEM, OP_BRANCH, OP_STORE, OP_OP).
  - decoded_t struct: pc, opcode, fmt, rd, rs1, rs2, funct3, funct7, imm, illegal. The pc and imm widths come from XLEN via package parameterisation or the maximum width truncated.
- Sub-module inst_decode_comb: purely combinational, in_inst to decoded_t fields. The top module holds the FIFO storage, pointers and handshake logic.

## Test plan
- addi x1,x2,-1 (0xFFF10093) at pc 0x100, out_ready=1 → next cycle out_valid=1, fmt=I, rd=1, rs1=2, funct3=0, rs2=0, imm=0xFFFFFFFF, pc=0x100.
- lui x5,0x12345 (0x123452B7) → fmt=U, rd=5, imm=0x12345000, rs1=rs2=funct3=0. With XLEN=64 and 0x800002B7 → imm=0xFFFFFFFF80000000.
- beq x1,x2,-4 (0xFE208EE3) → fmt=B, rs1=1, rs2=2, rd=0, imm=0xFFFFFFFC.
- DEPTH=2, out_ready=0, push 3 back-to-back:
  - count=2 and in_ready=0 after the 2nd push; the 3rd is held.
  - Then out_ready=1: PCs are popped in push order and the 3rd is accepted. count never exceeds 2.
- Two entries queued, flush=1 together with in_valid=1 → next cycle count=0, out_valid=0, and the offered instruction is absent.
- 0x00000000 → out_illegal=1, fmt=ILL, imm=0.
- mul x3,x1,x2 (0x022081B3) → illegal without DECODE_RV_M_EN. With the macro: fmt=R, rd=3, rs1=1, rs2=2, funct7=0x01.
